aes_decrypt_iter: RTL and testbench

- Iterative AES inverse cipher (FIPS-197) that executes one decryption round per clock.
- Generalises the team's combinational decryption core in two ways: key size is selected by the NK parameter (128/192/256), and the block has valid/ready handshakes on its input and output.
- Sits between the key-expansion unit, which supplies the round-key schedule w, and the system data path.
- Area is about one round of logic instead of NR unrolled rounds.

---
 rtl/aes_decrypt_iter.sv | 172 +++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one decryption round per clock, valid/ready on
// both sides. Key size chosen by NK (4/6/8 words).
// Optional macro AES_DEC_KEY_LATCH_EN: latch the whole round-key schedule at
// accept so w may change while rounds run.

// One state column through InvSubBytes, AddRoundKey and (optionally) InvMixColumns.
module aes_inv_col (
    input  logic [31:0] col_in,
    input  logic [31:0] rkey,
    input  logic        mix_en,
    output logic [31:0] col_out
);
    // GF(2^8) multiply mod x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box computed as inverse affine map followed by field inverse
    // (a^254), which keeps the 256-entry table out of the source.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a, p, r;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    logic [7:0] b0, b1, b2, b3;

    assign {b0, b1, b2, b3} = {inv_sbox(col_in[31:24]), inv_sbox(col_in[23:16]),
                               inv_sbox(col_in[15:8]),  inv_sbox(col_in[7:0])} ^ rkey;

    assign col_out = mix_en ?
        {gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09),
         gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d),
         gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b),
         gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e)} :
        {b0, b1, b2, b3};
endmodule

module aes_decrypt_iter #(
    parameter int NK = 4,
    parameter int NB = 4,
    parameter int NR = NK + 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              ciphertext,
    input  logic [32*NB*(NR+1)-1:0]   w,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              plaintext,
    output logic                      busy
);
    localparam int WW = 32 * NB * (NR + 1);
    localparam int CW = $clog2(NR + 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_decrypt_iter: NK must be 4, 6 or 8");
    end
    if (NB != 4) begin : g_bad_nb
        $error("aes_decrypt_iter: NB must be 4");
    end
    if (NR != NK + 6) begin : g_bad_nr
        $error("aes_decrypt_iter: NR is derived and must equal NK+6");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   round_ctr;
    logic [127:0]    st, shifted, rkey, rnd_out;
    logic [WW-1:0]   wk;
    logic            accept;

    assign accept = (state == IDLE) && in_valid;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [WW-1:0] w_q;
    // Snapshot the schedule at accept; rounds only see the copy
    always_ff @(posedge clk) begin
        if (rst)         w_q <= '0;
        else if (accept) w_q <= w;
    end
    assign wk = w_q;
`else
    assign wk = w;
`endif

    // Round key for round r is words r*NB..r*NB+3, contiguous in w
    assign rkey = wk[int'(round_ctr)*32*NB +: 128];

    // InvShiftRows: output column c row k comes from input column (c-k) mod 4
    for (genvar c = 0; c < 4; c++) begin : g_shift
        for (genvar k = 0; k < 4; k++) begin : g_row
            assign shifted[32*c+31-8*k -: 8] = st[32*((c-k+4)%4)+31-8*k -: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_inv_col u_col (
            .col_in  (shifted[32*c +: 32]),
            .rkey    (rkey[32*c +: 32]),
            .mix_en  (round_ctr != '0),
            .col_out (rnd_out[32*c +: 32])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and Moore outputs (no input-to-output paths)
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = ROUND;
            end
            ROUND: begin
                if (round_ctr == '0) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: initial AddRoundKey on accept, one inverse round per ROUND cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            round_ctr <= '0;
            st        <= '0;
            plaintext <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st        <= ciphertext ^ w[NR*32*NB +: 128];
                    round_ctr <= CW'(NR - 1);
                end
                ROUND: begin
                    st <= rnd_out;
                    if (round_ctr == '0) plaintext <= rnd_out;
                    else                 round_ctr <= round_ctr - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 / SP800-38A vectors on three
// instances (NK=4/6/8), latency, backpressure, streaming and mid-run reset.
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv[3], ir[3], ov[3], ordy[3], bz[3];
    logic [127:0] ct[3], pt[3];
    logic [1407:0] w4;
    logic [1663:0] w6;
    logic [1919:0] w8;

    int checks = 0;
    int failures = 0;

    logic [7:0] sbox[256];
    logic [1919:0] kw4a, kw4b, kw6, kw8;

    aes_decrypt_iter #(.NK(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .ciphertext(ct[0]), .w(w4), .out_valid(ov[0]), .out_ready(ordy[0]),
        .plaintext(pt[0]), .busy(bz[0]));
    aes_decrypt_iter #(.NK(6)) u6 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .ciphertext(ct[1]), .w(w6), .out_valid(ov[1]), .out_ready(ordy[1]),
        .plaintext(pt[1]), .busy(bz[1]));
    aes_decrypt_iter #(.NK(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .ciphertext(ct[2]), .w(w8), .out_valid(ov[2]), .out_ready(ordy[2]),
        .plaintext(pt[2]), .busy(bz[2]));

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Forward S-box built by walking generator 3 and its inverse
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Key expansion; key first byte at [255:248]
    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0] wd[60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [1919:0] wf;
        int total;
        wf = '0;
        rc = 8'h01;
        total = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) wf[32*i +: 32] = wd[i];
        return wf;
    endfunction

    // FIPS string order -> column layout (first byte at [31:24])
    function automatic logic [127:0] blk(input logic [127:0] x);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[32*c +: 32] = x[127-32*c -: 32];
        return o;
    endfunction

    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (ir[k] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", k, ir[k]); end
            checks++; if (ov[k] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", k, ov[k]); end
            checks++; if (bz[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, bz[k]); end
            checks++; if (pt[k] !== 128'h0) begin failures++; $display("FAIL reset_plaintext[%0d] got=%h exp=0", k, pt[k]); end
        end
    endtask

    // Full decrypt on instance k: accept, measure latency, check result, handshake
    task automatic do_decrypt(input int k, input logic [127:0] c, input logic [127:0] e,
                              input int lat, input bit corrupt);
        int n;
        @(negedge clk);
        checks++; if (ir[k] !== 1'b1) begin failures++; $display("FAIL pre_accept_ready[%0d] got=%b exp=1", k, ir[k]); end
        ct[k] = c;
        iv[k] = 1'b1;
        @(posedge clk);
        #1 iv[k] = 1'b0;
        ct[k] = '0;
        if (corrupt) w4 = ~w4;
        checks++; if (bz[k] !== 1'b1 || ir[k] !== 1'b0) begin failures++; $display("FAIL accept_busy[%0d] got=%b/%b exp=1/0", k, bz[k], ir[k]); end
        n = 0;
        while (ov[k] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n != lat) begin failures++; $display("FAIL latency[%0d] got=%0d exp=%0d", k, n, lat); end
        checks++; if (pt[k] !== e) begin failures++; $display("FAIL plaintext[%0d] got=%h exp=%h", k, pt[k], e); end
        ordy[k] = 1'b1;
        @(posedge clk);
        #1 ordy[k] = 1'b0;
        checks++; if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin failures++; $display("FAIL handshake[%0d] got=%b/%b exp=0/1", k, ov[k], ir[k]); end
        if (corrupt) w4 = ~w4;
    endtask

    task automatic test_kat();
        do_decrypt(0, blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a), blk(PT_C), 10, 1'b0);
        do_decrypt(1, blk(128'hdda97ca4864cdfe06eaf70a0ec0d7191), blk(PT_C), 12, 1'b0);
        do_decrypt(2, blk(128'h8ea2b7ca516745bfeafc49904b496089), blk(PT_C), 14, 1'b0);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        ct[0] = blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n != 10) begin failures++; $display("FAIL bp_latency got=%0d exp=10", n); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            iv[0] = (i == 5);
            ct[0] = blk(128'h8ea2b7ca516745bfeafc49904b496089);
            @(posedge clk);
            #1;
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || pt[0] !== blk(PT_C)) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b/%b/%h exp=1/0/%h", i, ov[0], ir[0], pt[0], blk(PT_C));
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        checks++; if (ir[0] !== 1'b1 || bz[0] !== 1'b0) begin failures++; $display("FAIL bp_no_accept got=%b/%b exp=1/0", ir[0], bz[0]); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cts[3], exps[3];
        int tacc[3];
        int idx, oidx, cyc;
        bit acc;
        cts[0] = blk(128'h3ad77bb40d7a3660a89ecaf32466ef97); exps[0] = blk(128'h6bc1bee22e409f96e93d7e117393172a);
        cts[1] = blk(128'hf5d3d58503b9699de785895a96fdbaaf); exps[1] = blk(128'hae2d8a571e03ac9c9eb76fac45af8e51);
        cts[2] = blk(128'h43b1cd7f598ece23881b00e3ed030688); exps[2] = blk(128'h30c81c46a35ce411e5fbc1191a0a52ef);
        for (int i = 0; i < 3; i++) tacc[i] = 0;
        w4 = kw4b[1407:0];
        ordy[0] = 1'b1;
        idx = 0; oidx = 0; cyc = 0;
        while (oidx < 3 && cyc < 100) begin
            @(negedge clk);
            iv[0] = (idx < 3);
            if (idx < 3) ct[0] = cts[idx];
            acc = iv[0] && ir[0];
            if (ov[0] === 1'b1) begin
                checks++;
                if (pt[0] !== exps[oidx]) begin failures++; $display("FAIL stream_pt[%0d] got=%h exp=%h", oidx, pt[0], exps[oidx]); end
                oidx++;
            end
            @(posedge clk);
            if (acc) begin tacc[idx] = cyc; idx++; end
            cyc++;
        end
        #1 iv[0] = 1'b0;
        ordy[0] = 1'b0;
        checks++; if (oidx != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", oidx); end
        checks++; if (tacc[1] - tacc[0] != 12) begin failures++; $display("FAIL stream_gap01 got=%0d exp=12", tacc[1] - tacc[0]); end
        checks++; if (tacc[2] - tacc[1] != 12) begin failures++; $display("FAIL stream_gap12 got=%0d exp=12", tacc[2] - tacc[1]); end
        w4 = kw4a[1407:0];
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        ct[0] = blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (ir[0] !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", ir[0]); end
        checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", ov[0]); end
        checks++; if (pt[0] !== 128'h0) begin failures++; $display("FAIL midrst_plaintext got=%h exp=0", pt[0]); end
        checks++; if (bz[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bz[0]); end
        do_decrypt(0, blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a), blk(PT_C), 10, 1'b0);
    endtask

`ifdef AES_DEC_KEY_LATCH_EN
    task automatic test_key_latch();
        do_decrypt(0, blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a), blk(PT_C), 10, 1'b1);
    endtask
`endif

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; ct[k] = '0;
        end
        build_sbox();
        kw4a = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        kw4b = expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        kw6  = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        kw8  = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        w4 = kw4a[1407:0];
        w6 = kw6[1663:0];
        w8 = kw8;
        test_reset();
        test_kat();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef AES_DEC_KEY_LATCH_EN
        test_key_latch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
